// File: rtl/pll_cal_ctrl.sv
// PLL VCO code calibration: SAR coarse search on feedback tick counts, then +/-1 tracking with lock detect.
// Define PLL_CAL_PFD_TRACK_EN to track from PFD up/down pulses instead of the window count.
module pll_cal_ctrl #(
    parameter int CODE_W   = 6,
    parameter int CNT_W    = 8,
    parameter int WINDOW   = 64,
    parameter int SETTLE   = 16,
    parameter int TARGET   = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              fb_tick,
`ifdef PLL_CAL_PFD_TRACK_EN
    input  logic              up,
    input  logic              down,
`endif
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              cal_done,
    output logic              locked,
    output logic              sat_err,
    output logic [CNT_W-1:0]  meas_cnt
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int LCK_W   = $clog2(LOCK_CNT + 1);

    localparam logic [TMR_W-1:0]  WIN_LD    = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0]  SET_LD    = TMR_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  TGT       = CNT_W'(TARGET);
    localparam logic [LCK_W-1:0]  LCK_MAX   = LCK_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0] CODE_MSB  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);

    localparam logic [2:0] S_IDLE         = 3'd0,
                           S_SETTLE       = 3'd1,
                           S_MEASURE      = 3'd2,
                           S_SAR_DECIDE   = 3'd3,
                           S_TRACK        = 3'd4,
                           S_TRACK_SETTLE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic [LCK_W-1:0]  lcnt_q, lcnt_d;
    logic              done_q, done_d;
    logic              lock_q, lock_d;
    logic              sat_q, sat_d;

    logic [CNT_W-1:0]  tick_inc;
    logic [CODE_W-1:0] trial_mask;
    logic [LCK_W-1:0]  lcnt_inc;
    logic              in_tol, want_up, want_dn;

    assign tick_inc   = (tick_q == '1) ? tick_q : tick_q + {{(CNT_W-1){1'b0}}, fb_tick};
    assign trial_mask = CODE_ONE << idx_q;
    assign lcnt_inc   = (lcnt_q == LCK_MAX) ? lcnt_q : lcnt_q + 1'b1;

`ifdef PLL_CAL_PFD_TRACK_EN
    localparam logic signed [CNT_W:0] TOL_P   = (CNT_W+1)'(TOL);
    localparam logic signed [CNT_W:0] TOL_N   = -TOL_P;
    localparam logic signed [CNT_W:0] ACC_ONE = (CNT_W+1)'(1);

    logic signed [CNT_W:0] acc_q, acc_d;

    assign want_up = acc_q > TOL_P;
    assign want_dn = acc_q < TOL_N;
    assign in_tol  = !want_up && !want_dn;
`else
    logic [CNT_W-1:0] err_mag;

    // Magnitude taken larger-minus-smaller so the unsigned subtract never wraps.
    assign err_mag = (meas_q >= TGT) ? (meas_q - TGT) : (TGT - meas_q);
    assign in_tol  = err_mag <= CNT_W'(TOL);
    assign want_up = meas_q < TGT;
    assign want_dn = meas_q > TGT;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        tick_d  = tick_q;
        meas_d  = meas_q;
        lcnt_d  = lcnt_q;
        done_d  = done_q;
        lock_d  = lock_q;
        sat_d   = sat_q;
`ifdef PLL_CAL_PFD_TRACK_EN
        acc_d   = acc_q;
`endif
        if (!en) begin
            state_d = S_IDLE;
            lock_d  = 1'b0;
            lcnt_d  = '0;
            tmr_d   = '0;
            tick_d  = '0;
        end else if (start) begin
            state_d = S_SETTLE;
            code_d  = CODE_MSB;
            idx_d   = IDX_W'(CODE_W - 1);
            tmr_d   = SET_LD;
            tick_d  = '0;
            lcnt_d  = '0;
            done_d  = 1'b0;
            lock_d  = 1'b0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                S_SETTLE, S_TRACK_SETTLE: begin
                    if (tmr_q == '0) state_d = S_MEASURE;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                S_MEASURE: begin
                    tick_d = tick_inc;
`ifdef PLL_CAL_PFD_TRACK_EN
                    if (done_q && up && !down)      acc_d = acc_q + ACC_ONE;
                    else if (done_q && down && !up) acc_d = acc_q - ACC_ONE;
`endif
                    if (tmr_q == '0) begin
                        meas_d  = tick_inc;
                        state_d = done_q ? S_TRACK : S_SAR_DECIDE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_SAR_DECIDE: begin
                    if (meas_q > TGT) code_d = code_q & ~trial_mask;
                    if (idx_q != '0) begin
                        code_d  = code_d | (trial_mask >> 1);
                        idx_d   = idx_q - 1'b1;
                        tmr_d   = SET_LD;
                        state_d = S_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_MEASURE;
                    end
                end
                S_TRACK: begin
                    if (in_tol) begin
                        lcnt_d  = lcnt_inc;
                        lock_d  = (lcnt_inc == LCK_MAX);
                        state_d = S_MEASURE;
                    end else begin
                        lcnt_d = '0;
                        lock_d = 1'b0;
                        if ((want_up && code_q == CODE_MAX) || (want_dn && code_q == '0)) begin
                            sat_d   = 1'b1;
                            state_d = S_MEASURE;
                        end else begin
                            code_d  = want_up ? code_q + CODE_ONE : code_q - CODE_ONE;
                            tmr_d   = SET_LD;
                            state_d = S_TRACK_SETTLE;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Every path into a window restarts the timer and the tick count.
        if (state_d == S_MEASURE && state_q != S_MEASURE) begin
            tmr_d  = WIN_LD;
            tick_d = '0;
`ifdef PLL_CAL_PFD_TRACK_EN
            acc_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= CODE_MSB;
            idx_q   <= '0;
            tmr_q   <= '0;
            tick_q  <= '0;
            meas_q  <= '0;
            lcnt_q  <= '0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
            sat_q   <= 1'b0;
`ifdef PLL_CAL_PFD_TRACK_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            tick_q  <= tick_d;
            meas_q  <= meas_d;
            lcnt_q  <= lcnt_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
            sat_q   <= sat_d;
`ifdef PLL_CAL_PFD_TRACK_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign code     = code_q;
    assign busy     = (state_q != S_IDLE);
    assign cal_done = done_q;
    assign locked   = lock_q;
    assign sat_err  = sat_q;
    assign meas_cnt = meas_q;

endmodule

// File: tb/tb_pll_cal_ctrl.sv
// Bench for pll_cal_ctrl: a plant turns the VCO code into fb_tick pulses; SAR/tracking outcomes come from a window-level model.
module tb_pll_cal_ctrl;
    localparam int CODE_W   = 6;
    localparam int TARGET   = 8;
    localparam int TOL      = 1;
    localparam int SAR_CYC  = CODE_W * (16 + 64 + 1);
    localparam int WIN_CYC  = 64 + 1;
    localparam int STEP_CYC = 64 + 1 + 16;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1, en = 1'b0, start = 1'b0, fb_tick = 1'b0;
    logic [5:0] code;
    logic       busy, cal_done, locked, sat_err;
    logic [7:0] meas_cnt;

    int checks = 0, failures = 0;
    int pl_sh = 1, pl_off = 0, t_ph = 0;

    typedef struct {
        int sh; int off; int exp_sar; int exp_steps; int exp_final; bit exp_sat; int exp_meas;
    } vec_t;
    vec_t vecs[5];

    pll_cal_ctrl dut (
        .clk_in(clk_in), .rst(rst), .en(en), .start(start), .fb_tick(fb_tick),
        .code(code), .busy(busy), .cal_done(cal_done), .locked(locked),
        .sat_err(sat_err), .meas_cnt(meas_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic int plant(int c, int sh, int off);
        int n;
        n = (c >> sh) + off;
        if (n < 0) n = 0;
        if (n > 64) n = 64;
        return n;
    endfunction

    // Ticks spread evenly over a 64-cycle period, so any 64 consecutive cycles hold exactly n ticks.
    always @(negedge clk_in) begin : tick_gen
        int n;
        n = plant(int'(code), pl_sh, pl_off);
        fb_tick = (((t_ph + 1) * n) / 64) != ((t_ph * n) / 64);
        t_ph = (t_ph + 1) % 64;
    end

    function automatic int sar_model(int sh, int off);
        int c;
        c = 0;
        for (int b = CODE_W - 1; b >= 0; b--)
            if (plant(c | (1 << b), sh, off) <= TARGET) c = c | (1 << b);
        return c;
    endfunction

    task automatic track_model(input int c0, input int sh, input int off,
                               output int c, output int steps, output bit sat);
        int n;
        c = c0; steps = 0; sat = 1'b0;
        for (int k = 0; k < 64; k++) begin
            n = plant(c, sh, off);
            if (n >= TARGET - TOL && n <= TARGET + TOL) break;
            if (n > TARGET) begin
                if (c == 0) begin sat = 1'b1; break; end
                c--;
            end else begin
                if (c == (1 << CODE_W) - 1) begin sat = 1'b1; break; end
                c++;
            end
            steps++;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // which: 0 cal_done high, 1 locked high, 2 locked low, 3 sat_err high
    task automatic wait_ev(input int which, input int bound, input string name, output int n);
        bit hit;
        n = 0;
        forever begin
            case (which)
                0:       hit = cal_done;
                1:       hit = locked;
                2:       hit = !locked;
                default: hit = sat_err;
            endcase
            if (hit || n >= bound) break;
            @(posedge clk_in); #1;
            n++;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles", name, bound);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_in); start = 1'b1;
        @(posedge clk_in); #1; start = 1'b0;
    endtask

    task automatic run_cal(input string tag, input int sh, input int off, input int exp_sar,
                           input int exp_steps, input int exp_final, input bit exp_sat, input int exp_meas);
        int n;
        pl_sh = sh; pl_off = off;
        pulse_start();
        check({tag, "_start_code"}, int'(code), 32);
        check({tag, "_start_flags"}, {busy, cal_done, locked, sat_err}, 4'b1000);
        wait_ev(0, 1000, {tag, "_cal_done"}, n);
        check_rng({tag, "_sar_cycles"}, n, SAR_CYC - 2, SAR_CYC + 2);
        check({tag, "_sar_code"}, int'(code), exp_sar);
        if (!exp_sat) begin
            wait_ev(1, 3000, {tag, "_lock"}, n);
            check({tag, "_lock_cycles"}, n, exp_steps * STEP_CYC + 4 * WIN_CYC);
            check({tag, "_lock_code"}, int'(code), exp_final);
            check({tag, "_lock_sat"}, int'(sat_err), 0);
        end else begin
            wait_ev(3, 3000, {tag, "_sat"}, n);
            check({tag, "_sat_cycles"}, n, exp_steps * STEP_CYC + WIN_CYC);
            check({tag, "_sat_code"}, int'(code), exp_final);
            check({tag, "_sat_locked"}, int'(locked), 0);
        end
        check({tag, "_meas"}, int'(meas_cnt), exp_meas);
    endtask

    initial begin
        int n, n1, fin, steps, sh, off, sar;
        bit sat;

        vecs[0] = '{1, 0, 17, 0, 17, 1'b0, 8};
        vecs[1] = '{0, 0, 8, 0, 8, 1'b0, 8};
        vecs[2] = '{6, 0, 63, 0, 63, 1'b1, 0};
        vecs[3] = '{2, 3, 23, 0, 23, 1'b0, 8};
        vecs[4] = '{0, 60, 0, 0, 0, 1'b1, 60};

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_code", int'(code), 32);
        check("rst_flags", {busy, cal_done, locked, sat_err}, 4'b0000);
        check("rst_meas", int'(meas_cnt), 0);
        @(negedge clk_in); rst = 1'b0; en = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        check("idle_no_start_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++)
            run_cal($sformatf("vec%0d", i), vecs[i].sh, vecs[i].off, vecs[i].exp_sar,
                    vecs[i].exp_steps, vecs[i].exp_final, vecs[i].exp_sat, vecs[i].exp_meas);

        // Lock on the nominal plant, then shift it by +3 ticks while locked.
        run_cal("nom", 1, 0, 17, 0, 17, 1'b0, 8);
        pl_off = 3;
        track_model(17, 1, 3, fin, steps, sat);
        wait_ev(2, 500, "shift_unlock", n1);
        check("shift_unlock_cycles", n1, WIN_CYC);
        check("shift_first_step", int'(code), 16);
        wait_ev(1, 3000, "shift_relock", n);
        check("shift_relock_cycles", n1 + n, steps * STEP_CYC + 4 * WIN_CYC);
        check("shift_relock_code", int'(code), fin);

        // en dropped while locked.
        @(negedge clk_in); en = 1'b0;
        @(posedge clk_in); #1;
        check("endrop_flags", {busy, cal_done, locked}, 3'b010);
        repeat (5) @(posedge clk_in);
        #1;
        check("endrop_code_held", int'(code), fin);
        pl_off = 0;
        @(negedge clk_in); en = 1'b1; start = 1'b1;
        @(posedge clk_in); #1; start = 1'b0;
        check("reen_code", int'(code), 32);
        check("reen_flags", {busy, cal_done}, 2'b10);
        wait_ev(0, 1000, "reen_cal_done", n);
        check("reen_code_final", int'(code), 17);

        // Restart while the bit-3 trial is in progress.
        pulse_start();
        repeat (181) @(posedge clk_in);
        #1;
        check("midsar_trial_code", int'(code), 24);
        pulse_start();
        check("midsar_restart_code", int'(code), 32);
        check("midsar_restart_flags", {busy, cal_done, sat_err}, 3'b100);
        wait_ev(0, 1000, "midsar_cal_done", n);
        check_rng("midsar_sar_cycles", n, SAR_CYC - 2, SAR_CYC + 2);
        check("midsar_code", int'(code), 17);

        // start and en falling together: en wins, code is not reloaded.
        @(negedge clk_in); en = 1'b0; start = 1'b1;
        @(posedge clk_in); #1; start = 1'b0;
        check("en_wins_busy", int'(busy), 0);
        check("en_wins_code", int'(code), 17);
        @(negedge clk_in); en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sh  = int'($urandom_range(0, 2));
            off = int'($urandom_range(0, 8)) - 4;
            sar = sar_model(sh, off);
            track_model(sar, sh, off, fin, steps, sat);
            run_cal($sformatf("rnd%0d", i), sh, off, sar, steps, fin, sat, plant(fin, sh, off));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_cal_ctrl.md
Name: pll_cal_ctrl

Overview:
- Digital calibration and lock controller for the PLL loop (PFD, VCO, feedback divider).
- Runs on the reference clock.
- Counts divided-feedback ticks over fixed reference windows and drives a digital VCO control code. It first runs a successive-approximation (SAR) coarse search, then ±1 tracking.
- Reports calibration done, lock and saturation error to the system.

Parameters:
- CODE_W, 6: width of VCO control code.
- CNT_W, 8: width of feedback tick counter; saturates at 2^CNT_W-1.
- WINDOW, 64: measurement window length, in clk_in cycles.
- SETTLE, 16: wait after every code change before measuring, in clk_in cycles.
- TARGET, 8: expected fb_tick count per window.
- TOL, 1: allowed |count-TARGET| for an in-tolerance window.
- LOCK_CNT, 4: consecutive in-tolerance windows needed to assert locked.

Ports:
- clk_in  input  1  reference clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low forces IDLE and holds code.
- start  input  1  one-cycle pulse; begins or restarts calibration.
- fb_tick  input  1  one-cycle pulse per divided feedback edge, already synchronised to clk_in.
- code  output  CODE_W  VCO control code.
- busy  output  1  high in any state except IDLE.
- cal_done  output  1  high once SAR completes; cleared by start.
- locked  output  1  lock indication.
- sat_err  output  1  sticky; code saturated while a correction was still required.
- meas_cnt  output  CNT_W  count from the last completed window.

Behaviour:
- Reset values: code=2^(CODE_W-1), all flags 0, meas_cnt=0, state IDLE, internal counters 0.
- FSM states: IDLE, SETTLE, MEASURE, SAR_DECIDE, TRACK, TRACK_SETTLE.
- IDLE: start&&en -> SAR begins.
  - code = MSB only (bit index CODE_W-1 set as trial).
  - cal_done, locked, sat_err cleared.
  - Next state SETTLE.
- SETTLE: counts SETTLE cycles, then MEASURE.
- MEASURE:
  - Clears tick counter on entry; counts fb_tick for exactly WINDOW cycles.
  - A tick in the last window cycle is counted.
  - Counter saturates, no wrap.
  - At window end: meas_cnt <= count.
  - Next state is SAR_DECIDE during SAR, TRACK during tracking.
- SAR_DECIDE (1 cycle):
  - If count > TARGET, clear the current trial bit.
  - If the bit index > 0: set the next lower bit as trial, decrement index, go to SETTLE.
  - Else: cal_done <= 1, go to MEASURE (tracking); no settle, since code is unchanged.
- TRACK (1 cycle, evaluates the window):
  - In tolerance: lock counter +1, saturating at LOCK_CNT; locked=1 when it reaches LOCK_CNT. Return to MEASURE.
  - Out of tolerance: lock counter=0, locked=0 in the same cycle.
  - count>TARGET: code-1; count<TARGET: code+1.
  - Then TRACK_SETTLE (SETTLE cycles), then MEASURE.
- Saturation: a required step past 0 or 2^CODE_W-1 leaves code unchanged, sets sat_err (sticky), and returns directly to MEASURE.
- Start mid-operation: immediate SAR restart from MSB; counters cleared; flags cleared.
- en low: next cycle IDLE; code and meas_cnt held; locked=0; cal_done retained.
- start and en falling in the same cycle: en wins (IDLE).
- Arithmetic: compares are unsigned on CNT_W. Tolerance uses |count-TARGET| computed without underflow.

Optional Feature:
- Macro: PLL_CAL_PFD_TRACK_EN.
- When defined:
  - Adds inputs up and down (1 bit each), synchronised pulses from the PFD.
  - During tracking windows a signed accumulator of width CNT_W+1 counts up(+1) and down(-1); both high in the same cycle counts 0.
  - Correction direction: acc>TOL -> code+1; acc<-TOL -> code-1. Otherwise in tolerance.
  - The window count drives meas_cnt only.
  - SAR is unchanged.
- When undefined: no up/down ports; tracking uses the window count as above.

Test Plan:
- Bench model fb_tick count = floor(code/2) per window; rst, then en=1, start -> SAR trials 32,16,24,20,18,17 give final code=17. cal_done rises 6×(16+64)+6 cycles after start, ±2. locked rises 4 windows (256 cycles + 4) later; meas_cnt=8.
- Model switched mid-track to count=floor(code/2)+3 -> locked drops at the first window end. Code steps down by 1 per window+settle until |err|<=1, then locked re-asserts after 4 windows.
- Model constant count=0 -> SAR ends at code=63; tracking requests +1, so sat_err=1, code stays 63, locked stays 0.
- start pulsed during SAR bit 3 -> code returns to 32 next cycle; cal_done and sat_err are 0; sequence completes normally.
- en dropped while locked -> busy=0 and locked=0 next cycle; code held. en=1 plus start -> full recalibration.
- With PLL_CAL_PFD_TRACK_EN: after SAR, drive 5 up pulses and 1 down pulse per window -> code +1 per window. Balanced up/down -> locked after 4 windows.
